key_filter: RTL

- Debounces one raw mechanical key and emits a single-clock press strobe.
- This strobe is the producer side of the key-pulse interface that the hex key counter and other key consumers sample as a one-cycle increment or enable.
- Sits between the board key pin and any logic needing clean key events.
- Also provides a stable debounced level and a release strobe.

---
 rtl/key_filter_pkg.sv | 27 ++
 rtl/key_filter_sync_2ff.sv | 37 +++
 rtl/key_filter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/key_filter_pkg.sv
// -----------------------------------------------------------------------------
// key_filter_pkg
// Shared definitions for the key-handling blocks: debounce FSM state encoding,
// default board timing constants (50 MHz clock) and a counter-width helper.
// No ports; imported with "import key_filter_pkg::*".
// -----------------------------------------------------------------------------
package key_filter_pkg;

    // Debounce FSM state encoding, shared with other key consumers.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_DOWN     = 2'd2,
        ST_REL_DB   = 2'd3
    } key_state_e;

    // Default timing at 50 MHz: 20 ms debounce, 1 s long press, 200 ms repeat.
    localparam int KEY_DEBOUNCE_DEFAULT = 32'd1_000_000;
    localparam int KEY_LONG_DEFAULT     = 32'd50_000_000;
    localparam int KEY_REPEAT_DEFAULT   = 32'd10_000_000;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
    function automatic int key_cnt_width(input int n);
        return (n < 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage : key_filter_pkg

// File: rtl/key_filter_sync_2ff.sv
// -----------------------------------------------------------------------------
// key_filter_sync_2ff
// Generic 1-bit two-flop synchronizer for asynchronous board inputs.
// Both flops reset to RST_VAL so the synchronized value starts at a known,
// inactive level.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous, active-high reset
//   i_d  - asynchronous input
//   o_q  - synchronized output (two clocks of latency)
// -----------------------------------------------------------------------------
module key_filter_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : key_filter_sync_2ff

// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
// Debounces one raw mechanical key. Produces a debounced level plus one-clock
// press and release strobes (the press strobe feeds counters/enables).
// Optional feature macro: KEY_FILTER_AUTO_REPEAT_EN -- when defined, a held
// key re-issues press_pulse after LONG_CYCLES and then every REPEAT_CYCLES
// (REPEAT_CYCLES must not exceed LONG_CYCLES).
// Ports:
//   clk           - system clock
//   rst           - asynchronous, active-high reset
//   key_in        - raw key pin, asynchronous to clk
//   key_level     - debounced level, 1 = pressed
//   press_pulse   - one-clock strobe on accepted press (and repeats)
//   release_pulse - one-clock strobe on accepted release
// -----------------------------------------------------------------------------
module key_filter
    import key_filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int ACTIVE_LOW      = 32'sd1,
    parameter int LONG_CYCLES     = KEY_LONG_DEFAULT,
    parameter int REPEAT_CYCLES   = KEY_REPEAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = key_cnt_width(DEBOUNCE_CYCLES);
    // The cycle in which the stable FSM state (IDLE/DOWN) first sees the new
    // level is the first of the DEBOUNCE_CYCLES stable samples, so the
    // debounce state only has to count the remaining DEBOUNCE_CYCLES-1.
    // That keeps edge-to-pulse latency at exactly 2+DEBOUNCE_CYCLES clocks.
    localparam logic [CW-1:0] DB_TERM      = CW'(DEBOUNCE_CYCLES - 32'sd2);
    localparam logic          RAW_RELEASED = (ACTIVE_LOW != 32'sd0) ? 1'b1 : 1'b0;

    logic            w_key_sync;
    logic            w_pressed;
    key_state_e      r_state;
    key_state_e      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_level_nxt;
    logic            w_repeat_hit;
    logic            r_press;
    logic            r_release;
    logic            r_level;

    key_filter_sync_2ff #(
        .RST_VAL (RAW_RELEASED)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (key_in),
        .o_q (w_key_sync)
    );

    assign w_pressed = (ACTIVE_LOW != 32'sd0) ? ~w_key_sync : w_key_sync;

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and debounce counter logic; counter never passes DB_TERM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = ST_PRESS_DB;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS_DB: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == DB_TERM) begin
                    w_state_nxt = ST_DOWN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DOWN: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_REL_DB;
                end else begin
                    w_state_nxt = ST_DOWN;
                end
            end
            ST_REL_DB: begin
                if (w_pressed) begin
                    w_state_nxt = ST_DOWN;
                end else if (r_cnt == DB_TERM) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef KEY_FILTER_AUTO_REPEAT_EN
    localparam int HW = key_cnt_width(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_TERM   = HW'(LONG_CYCLES - 32'sd1);
    // Reloading to LONG-REPEAT makes the next hit exactly REPEAT clocks later.
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(LONG_CYCLES - REPEAT_CYCLES);

    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;

    // Hold counter register for auto-repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end

    // Hold counter runs only while the key stays DOWN; any exit clears it.
    always_comb begin
        w_repeat_hit = 1'b0;
        w_hold_nxt   = '0;
        if ((r_state == ST_DOWN) && (w_state_nxt == ST_DOWN)) begin
            if (r_hold == HOLD_TERM) begin
                w_repeat_hit = 1'b1;
                w_hold_nxt   = HOLD_RELOAD;
            end else begin
                w_hold_nxt   = r_hold + HW'(1);
            end
        end else begin
            w_hold_nxt   = '0;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(LONG_CYCLES), 32'(REPEAT_CYCLES)};
    assign w_repeat_hit = 1'b0;
`endif

    // Output decode from the transition being taken this cycle.
    always_comb begin
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_level_nxt   = 1'b0;
        if ((r_state == ST_PRESS_DB) && (w_state_nxt == ST_DOWN)) begin
            w_press_nxt = 1'b1;
        end else begin
            w_press_nxt = w_repeat_hit;
        end
        if ((r_state == ST_REL_DB) && (w_state_nxt == ST_IDLE)) begin
            w_release_nxt = 1'b1;
        end else begin
            w_release_nxt = 1'b0;
        end
        if ((w_state_nxt == ST_DOWN) || (w_state_nxt == ST_REL_DB)) begin
            w_level_nxt = 1'b1;
        end else begin
            w_level_nxt = 1'b0;
        end
    end

    // Registered outputs, so level and strobes change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_level   <= w_level_nxt;
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign key_level     = r_level;

endmodule : key_filter
